add_share_arbiter: RTL
======================

Name: add_share_arbiter

Overview:
- Shares one 32-bit adder between NUM_REQ requesters, e.g. PC+4 incrementer, branch-target calc and address-offset unit in the multi-cycle datapath.
- Each requester presents operands with a valid/ready handshake.
- The arbiter grants round-robin, registers the sum with carry and signed-overflow flags, and holds the result until the owner acknowledges.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- WIDTH, 32, operand/result width.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous reset, active-high.
- ReqValid  in  NUM_REQ  bit i: requester i has operands pending.
- ReqA  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- ReqB  in  NUM_REQ*WIDTH  operand B; same packing as ReqA.
- ReqReady  out  NUM_REQ  one-hot grant; operands of requester i are captured this cycle.
- RespValid  out  NUM_REQ  one-hot; the result belongs to requester i.
- RespResult  out  WIDTH  registered A+B.
- RespCarry  out  1  unsigned carry-out of the sum.
- RespOverflow  out  1  signed overflow: A and B have the same sign and the result sign differs.
- RespId  out  clog2(NUM_REQ)  index of the result owner.
- RespAck  in  1  owner consumed the result; ignored while no RespValid bit is set.

Behaviour:
- Reset (Rst=1 at a Clk edge):
  - State=IDLE, RoundRobin pointer Ptr=0.
  - RespValid=0, RespResult=0, RespCarry=0, RespOverflow=0, RespId=0.
  - Any in-flight or held result is discarded.
  - ReqReady=0 during every cycle in which Rst=1.
- FSM states: IDLE, HOLD.
- Grant selection (combinational):
  - Scan ReqValid starting at index Ptr, wrapping modulo NUM_REQ; the first set bit wins.
  - ReqReady is driven only for the winner, and only when the FSM may accept: State=IDLE, or State=HOLD with RespAck=1.
  - ReqReady depends only on state, Ptr, ReqValid and RespAck, never on operand values.
- IDLE:
  - Winner exists: at the edge, capture {carry,sum}=A+B at WIDTH+1 bits, set overflow, RespId=winner, RespValid=onehot(winner), go to HOLD.
  - No winner: stay in IDLE, outputs unchanged, RespValid=0.
- HOLD:
  - RespValid, RespResult, RespCarry, RespOverflow and RespId are held stable until RespAck=1.
  - RespAck=1 with a new winner: capture the new result the same edge and stay in HOLD, giving back-to-back throughput of one add per cycle.
  - RespAck=1 with no winner: RespValid=0, go to IDLE; result registers keep their last value.
- Ptr update:
  - On every accepted request, Ptr=(winner+1) mod NUM_REQ.
  - No change otherwise.
- Latency: operands captured at edge N; the result is visible on the outputs right after edge N.
- Requester rules:
  - Hold ReqValid and operands stable until ReqReady is sampled high.
  - Dropping ReqValid before the grant is legal; the request simply disappears.
- Arithmetic: the sum wraps modulo 2^WIDTH. Carry and overflow are computed on the captured operands only.
- Simultaneous events:
  - All requesters valid: exactly one granted per acceptance, rotation guarantees each is served within NUM_REQ acceptances.
  - Rst wins over RespAck and ReqValid.
- Invariants:
  - ReqReady and RespValid are each at most one-hot.
  - RespValid is nonzero iff State=HOLD.

Test Plan:
- Reset, then ReqValid=001, A0=0x00000004, B0=0x00400000.
  - ReqReady=001 in that cycle.
  - Next cycle RespValid=001, RespResult=0x00400004, carry=0, ovf=0.
  - Hold RespAck=0 for 3 cycles: outputs unchanged, ReqReady stays 000 even with ReqValid=010.
- Boundaries:
  - A=0xFFFFFFFF, B=0x00000001 -> Result=0x00000000, carry=1, ovf=0.
  - A=0x7FFFFFFF, B=0x00000001 -> Result=0x80000000, carry=0, ovf=1.
  - A=0x80000000, B=0x80000000 -> Result=0, carry=1, ovf=1.
- Fairness: ReqValid=111 held constantly, RespAck=1 every cycle.
  - Grants repeat 001,010,100,001,... with one result per cycle.
  - RespId sequence 0,1,2,0.
- Pointer after skip: Ptr=1 and ReqValid=101 -> grant 100, then Ptr=0 -> next grant 001.
- Rst asserted while in HOLD with RespValid=010:
  - Next cycle RespValid=000, RespResult=0, Ptr=0.
  - After release, with ReqValid=110, the first grant is 010.
- Ack with no pending request: RespAck=1 in HOLD, ReqValid=000 -> State=IDLE, RespValid=000, RespResult keeps its last value.

Source files
------------

// File: rtl/add_share_arbiter.sv
// Round-robin share of one WIDTH-bit adder between NUM_REQ requesters.
// The registered result is held until the owner acks; ack plus a new winner gives one add per cycle.
module add_share_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]     req_a,
  input  logic [NUM_REQ*WIDTH-1:0]     req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [WIDTH-1:0]             resp_result,
  output logic                         resp_carry,
  output logic                         resp_overflow,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id,
  input  logic                         resp_ack
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                          state;
  logic [IDW-1:0]                  ptr;
  logic [NUM_REQ-1:0][WIDTH-1:0]   a_arr, b_arr;
  logic [IDW-1:0]                  win, ptr_nxt;
  logic                            found, accept, grant;
  logic [WIDTH-1:0]                a_sel, b_sel;
  logic [WIDTH:0]                  sum_ext;
  logic                            ovf;

  assign a_arr = req_a;
  assign b_arr = req_b;

  // Rotating priority: scan from ptr upward with wrap, first valid wins.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // A held result can be replaced in the same cycle it is acked.
  assign accept    = (state == IDLE) || resp_ack;
  assign grant     = found && accept && !rst;
  assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;

  assign a_sel   = a_arr[win];
  assign b_sel   = b_arr[win];
  assign sum_ext = {1'b0, a_sel} + {1'b0, b_sel};
  assign ovf     = (a_sel[WIDTH-1] == b_sel[WIDTH-1]) &&
                   (sum_ext[WIDTH-1] != a_sel[WIDTH-1]);
  assign ptr_nxt = (win == IDW'(NUM_REQ-1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      resp_valid    <= '0;
      resp_result   <= '0;
      resp_carry    <= 1'b0;
      resp_overflow <= 1'b0;
      resp_id       <= '0;
    end else if (grant) begin
      state         <= HOLD;
      ptr           <= ptr_nxt;
      resp_valid    <= req_ready;
      resp_result   <= sum_ext[WIDTH-1:0];
      resp_carry    <= sum_ext[WIDTH];
      resp_overflow <= ovf;
      resp_id       <= win;
    end else if (state == HOLD && resp_ack) begin
      state      <= IDLE;
      resp_valid <= '0;
    end
  end

endmodule
